// File: rtl/demultiplexer_1to2_buffered.sv
// demultiplexer_1to2_buffered: routes each input word to one of two independent FIFO-buffered valid/ready channels
module demultiplexer_1to2_buffered #(
  parameter int NBits = 32,
  parameter int Depth = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Selector,
  input  logic                     DEMUX_Valid_In,
  output logic                     DEMUX_Ready_In,
  input  logic [NBits-1:0]         DEMUX_Data,
  output logic                     DEMUX_Valid0,
  input  logic                     DEMUX_Ready0,
  output logic [NBits-1:0]         DEMUX_Output0,
  output logic                     DEMUX_Valid1,
  input  logic                     DEMUX_Ready1,
  output logic [NBits-1:0]         DEMUX_Output1,
  output logic [$clog2(Depth):0]   Count0,
  output logic [$clog2(Depth):0]   Count1
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  logic [1:0][CW-1:0]    cnt_v;
  logic [1:0][NBits-1:0] dout_v;
  logic [1:0]            rdy_v;
  assign rdy_v = {DEMUX_Ready1, DEMUX_Ready0};
  // admission looks only at registered occupancy, never at a same-cycle pop
  assign DEMUX_Ready_In = Selector ? (cnt_v[1] != CW'(Depth)) : (cnt_v[0] != CW'(Depth));
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [NBits-1:0] mem [Depth];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             push, pop;
    assign push = DEMUX_Valid_In && DEMUX_Ready_In && (Selector == 1'(c));
    assign pop  = (cnt != '0) && rdy_v[c];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        wp  <= push ? wp + 1'b1 : wp;
        rp  <= pop ? rp + 1'b1 : rp;
        cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
      end
    always_ff @(posedge clk)
      if (push) mem[wp] <= DEMUX_Data;
    assign cnt_v[c]  = cnt;
    assign dout_v[c] = (cnt != '0) ? mem[rp] : '0;
  end
  assign Count0        = cnt_v[0];
  assign Count1        = cnt_v[1];
  assign DEMUX_Valid0  = cnt_v[0] != '0;
  assign DEMUX_Valid1  = cnt_v[1] != '0;
  assign DEMUX_Output0 = dout_v[0];
  assign DEMUX_Output1 = dout_v[1];
endmodule

// File: tb/tb_demultiplexer_1to2_buffered.sv
// tb_demultiplexer_1to2_buffered: directed and randomized checks of the buffered 1-to-2 demultiplexer
module tb_demultiplexer_1to2_buffered;
  logic        clk = 0, reset = 1, sel = 0, vin = 0, r0 = 0, r1 = 0;
  logic        rin, v0, v1;
  logic [31:0] din = 0, o0, o1;
  logic [1:0]  c0, c1;
  int total = 0, bad = 0;
  logic [31:0] q0[$], q1[$];
  demultiplexer_1to2_buffered #(.NBits(32), .Depth(2)) dut (
    .clk(clk), .reset(reset), .Selector(sel), .DEMUX_Valid_In(vin), .DEMUX_Ready_In(rin),
    .DEMUX_Data(din), .DEMUX_Valid0(v0), .DEMUX_Ready0(r0), .DEMUX_Output0(o0),
    .DEMUX_Valid1(v1), .DEMUX_Ready1(r1), .DEMUX_Output1(o1), .Count0(c0), .Count1(c1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic p0, p1, acc, rexp;
    repeat (2) step();
    reset = 0;
    step();
    chk("rst_c0", 32'(c0), 0);
    chk("rst_c1", 32'(c1), 0);
    chk("rst_v0", 32'(v0), 0);
    chk("rst_v1", 32'(v1), 0);
    chk("rst_o0", o0, 0);
    chk("rst_rin_s0", 32'(rin), 1);
    sel = 1; #1;
    chk("rst_rin_s1", 32'(rin), 1);
    // single word routed to channel 1
    din = 32'hDEADBEEF; vin = 1;
    step();
    vin = 0;
    chk("single_v1", 32'(v1), 1);
    chk("single_o1", o1, 32'hDEADBEEF);
    chk("single_c1", 32'(c1), 1);
    chk("single_v0", 32'(v0), 0);
    r1 = 1;
    step();
    r1 = 0;
    chk("single_pop_c1", 32'(c1), 0);
    chk("single_pop_v1", 32'(v1), 0);
    // backpressure on channel 0 does not block channel 1
    sel = 0; vin = 1; din = 1;
    step();
    din = 2;
    step();
    vin = 0; #1;
    chk("full_c0", 32'(c0), 2);
    chk("full_rin_s0", 32'(rin), 0);
    sel = 1; #1;
    chk("full_rin_s1", 32'(rin), 1);
    vin = 1; din = 3;
    step();
    vin = 0;
    chk("bp_c1", 32'(c1), 1);
    chk("bp_o1", o1, 3);
    chk("bp_o0_hold", o0, 1);
    chk("bp_c0_hold", 32'(c0), 2);
    r0 = 1;
    step();
    chk("drain_o0_2", o0, 2);
    chk("drain_c0_1", 32'(c0), 1);
    step();
    chk("drain_c0_0", 32'(c0), 0);
    chk("drain_v0_0", 32'(v0), 0);
    r0 = 0; r1 = 1;
    step();
    r1 = 0;
    chk("drain_c1_0", 32'(c1), 0);
    // full channel refuses a push even when popped in the same cycle
    sel = 0; vin = 1; din = 4;
    step();
    din = 5;
    step();
    din = 6; r0 = 1; #1;
    chk("fpop_rin", 32'(rin), 0);
    step();
    r0 = 0;
    chk("fpop_c0", 32'(c0), 1);
    chk("fpop_o0", o0, 5);
    chk("fpop_rin_after", 32'(rin), 1);
    step();
    vin = 0;
    chk("fpop_accept_c0", 32'(c0), 2);
    chk("fpop_accept_o0", o0, 5);
    r0 = 1;
    step();
    chk("fpop_o0_6", o0, 6);
    step();
    r0 = 0;
    chk("fpop_empty", 32'(c0), 0);
    // streaming with wrap on channel 1
    sel = 1; r1 = 1;
    for (int i = 0; i < 10; i++) begin
      din = 32'h10 + i; vin = 1;
      step();
      chk("stream_v1", 32'(v1), 1);
      chk("stream_o1", o1, 32'h10 + i);
      chk("stream_c1", 32'(c1), 1);
    end
    vin = 0;
    step();
    r1 = 0;
    chk("stream_end_c1", 32'(c1), 0);
    // async reset with both channels full
    sel = 0; vin = 1; din = 32'hA0;
    step();
    din = 32'hA1;
    step();
    sel = 1; din = 32'hB0;
    step();
    din = 32'hB1;
    step();
    vin = 0;
    chk("pre_rst_c0", 32'(c0), 2);
    chk("pre_rst_c1", 32'(c1), 2);
    #2 reset = 1;
    #1;
    chk("arst_c0", 32'(c0), 0);
    chk("arst_c1", 32'(c1), 0);
    chk("arst_v0", 32'(v0), 0);
    chk("arst_v1", 32'(v1), 0);
    chk("arst_o0", o0, 0);
    chk("arst_o1", o1, 0);
    step();
    reset = 0;
    step();
    chk("post_rst_rin", 32'(rin), 1);
    // random interleave against queue model
    for (int n = 0; n < 1000; n++) begin
      sel = 1'($urandom); vin = 1'($urandom); r0 = 1'($urandom); r1 = 1'($urandom);
      din = $urandom;
      #1;
      rexp = sel ? (q1.size() != 2) : (q0.size() != 2);
      chk("rnd_rin", 32'(rin), 32'(rexp));
      chk("rnd_c0", 32'(c0), q0.size());
      chk("rnd_c1", 32'(c1), q1.size());
      chk("rnd_v0", 32'(v0), 32'(q0.size() != 0));
      chk("rnd_v1", 32'(v1), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("rnd_o0", o0, q0[0]);
      if (q1.size() != 0) chk("rnd_o1", o1, q1[0]);
      p0 = r0 && q0.size() != 0;
      p1 = r1 && q1.size() != 0;
      acc = vin && rexp;
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (sel) q1.push_back(din);
        else q0.push_back(din);
      end
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
